uart_rx_buffered: RTL

Parametrised UART receiver with 16x oversampling, configurable frame format, and an on-chip receive FIFO. It replaces the single-byte receiver between the board `uart_rx` pin and character consumers such as the OLED text path. Consumers drain bytes through a valid/ready stream instead of a one-cycle pulse, so back-pressure no longer loses characters silently. Frame, parity and overrun errors are reported as single-cycle pulses.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 76 +++++++
 rtl/uart_rx_buffered.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int OSR      = 16;
  localparam int VOTE_MID = 8;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO: head register is loaded on pop or on the first push into an empty FIFO.
module uart_rx_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_LEVEL  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      level_reg;
  logic [WIDTH-1:0] head_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == FULL_LEVEL);
  assign pop_ok  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rd_next = rd_ptr_reg + 1'b1;
  assign head    = head_reg;
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_next;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      // With one entry left, the next head can only be the byte arriving now.
      if (pop_ok) begin
        if (level_reg > ONE_LEVEL) begin
          head_reg <= mem[rd_next];
        end else if (push_ok) begin
          head_reg <= push_data;
        end
      end else if (push_ok && empty) begin
        head_reg <= push_data;
      end
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x oversampling UART receiver with majority vote, error pulses and a FWFT receive FIFO.
// Parity state and checker are present only when UART_RX_PARITY_EN is defined.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 6,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [7:0]                  data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("uart_rx_buffered: CLK_DIV must be >= 1");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
    $error("uart_rx_buffered: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_buffered: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end
`ifdef UART_RX_PARITY_EN
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_par
    $error("uart_rx_buffered: PARITY must be 0, 1 or 2");
  end
`else
  if (PARITY != PAR_NONE) begin : g_no_par
    $error("uart_rx_buffered: PARITY requires UART_RX_PARITY_EN");
  end
`endif

  logic             rx_meta_reg;
  logic             rx_sync_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;

  uart_rx_state_t   state_reg;
  uart_rx_state_t   state_next;
  logic [3:0]       samp_cnt_reg;
  logic [1:0]       vote_sh_reg;
  logic [2:0]       bit_cnt_reg;
  logic             bit_val_reg;
  logic [7:0]       data_reg;
  logic             stop_idx_reg;
  logic             stop_bad_reg;
  logic             frame_err_reg;
  logic             overrun_reg;

  logic             vote;
  logic             at_vote;
  logic             at_end;
  logic             last_stop;
  logic             last_data;
  logic             push_req;
  logic             frame_bad;
  logic             fifo_empty;
  logic             fifo_full;

`ifdef UART_RX_PARITY_EN
  logic             par_bad_reg;
  logic             parity_err_reg;
  logic             parity_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  assign tick = (div_cnt_reg == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  // The vote uses the samples taken at counts 7 and 8 plus the live one at 9.
  assign vote      = vote3(vote_sh_reg[1], vote_sh_reg[0], rx_sync_reg);
  assign at_vote   = tick && (samp_cnt_reg == 4'(VOTE_MID + 1));
  assign at_end    = tick && (samp_cnt_reg == 4'(OSR - 1));
  assign last_stop = (stop_idx_reg == 1'(STOP_BITS - 1));
  assign last_data = (bit_cnt_reg == 3'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    push_req   = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_sync_reg) state_next = START;
      end
      // A high vote rejects the edge at once; a valid start bit is held to its end.
      START: begin
        if (at_vote && vote)  state_next = IDLE;
        else if (at_end)      state_next = DATA;
      end
      DATA: begin
        if (at_end && last_data) begin
`ifdef UART_RX_PARITY_EN
          state_next = (PARITY != PAR_NONE) ? PARITY : STOP;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_end) state_next = STOP;
      end
`endif
      STOP: begin
        if (at_vote && last_stop) begin
          if (stop_bad_reg || !vote) begin
            frame_bad  = 1'b1;
            state_next = WAIT_IDLE;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad_reg) begin
            parity_bad = 1'b1;
            state_next = IDLE;
          end
`endif
          else begin
            push_req   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt_reg  <= '0;
      vote_sh_reg   <= 2'b11;
      bit_cnt_reg   <= '0;
      bit_val_reg   <= 1'b1;
      data_reg      <= '0;
      stop_idx_reg  <= 1'b0;
      stop_bad_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (state_next != state_reg) begin
        samp_cnt_reg <= '0;
      end else if (tick) begin
        samp_cnt_reg <= samp_cnt_reg + 1'b1;
      end
      if (tick && (samp_cnt_reg == 4'(VOTE_MID - 1) || samp_cnt_reg == 4'(VOTE_MID))) begin
        vote_sh_reg <= {vote_sh_reg[0], rx_sync_reg};
      end
      case (state_reg)
        IDLE: begin
          bit_cnt_reg  <= '0;
          data_reg     <= '0;
          stop_idx_reg <= 1'b0;
          stop_bad_reg <= 1'b0;
        end
        DATA: begin
          if (at_vote) bit_val_reg <= vote;
          if (at_end) begin
            data_reg[bit_cnt_reg] <= bit_val_reg;
            bit_cnt_reg           <= bit_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (at_vote && !last_stop) stop_bad_reg <= !vote;
          if (at_end) stop_idx_reg <= 1'b1;
        end
        default: ;
      endcase
      frame_err_reg <= frame_bad;
      overrun_reg   <= push_req && fifo_full && !data_ready;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        par_bad_reg <= 1'b0;
      end else if (state_reg == PARITY && at_vote) begin
        par_bad_reg <= vote ^ (^data_reg) ^ 1'(PARITY == PAR_ODD);
      end
      parity_err_reg <= parity_bad;
    end
  end
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign data_valid = !fifo_empty;

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (data_reg),
    .pop       (data_ready),
    .head      (data_out),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule
